// File: rtl/states_pkg.sv
// Shared state encodings for the memory-side blocks: the controller FSM and
// the per-channel responder FSM, plus the latency-counter sizing helper.
package states_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ISSUE,
        CTRL_WAIT,
        CTRL_RETIRE
    } controller_state_t;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP_READ_BUSY,
        RSP_WRITE_BUSY,
        RSP_READ_DONE,
        RSP_WRITE_DONE
    } responder_state_t;

    // Counter only ever holds LATENCY-1 down to 0; keep at least one bit.
    function automatic int cnt_width(input int latency);
        return (latency < 3) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/mem_responder_chan.sv
// One request channel: sample a read or write, count out the latency, then
// hold the response until the requester drops valid.
module mem_responder_chan
    import states_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_read_valid,
    input  logic [ADDR_BITS-1:0] i_read_address,
    input  logic                 i_write_valid,
    input  logic [ADDR_BITS-1:0] i_write_address,
    input  logic [DATA_BITS-1:0] i_write_data,
    input  logic [DATA_BITS-1:0] i_mem_rdata,
    output logic                 o_read_ready,
    output logic [DATA_BITS-1:0] o_read_data,
    output logic                 o_write_ready,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [DATA_BITS-1:0] o_wdata,
    output logic                 o_wr_commit
);

    localparam int               CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    responder_state_t     r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_read_ready;
    logic                 r_write_ready;
    logic                 w_cnt_zero;

    assign w_cnt_zero    = (r_cnt == '0);
    assign o_wr_commit   = (r_state == RSP_WRITE_BUSY) && w_cnt_zero;
    assign o_addr        = r_addr;
    assign o_wdata       = r_wdata;
    assign o_read_data   = r_rdata;
    assign o_read_ready  = r_read_ready;
    assign o_write_ready = r_write_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RSP_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_read_ready  <= 1'b0;
            r_write_ready <= 1'b0;
        end else begin
            case (r_state)
                RSP_IDLE: begin
                    // Read wins a tie; a held write_valid is picked up on a later visit to IDLE.
                    if (i_read_valid) begin
                        r_addr  <= i_read_address;
                        r_cnt   <= CNT_LOAD;
                        r_state <= RSP_READ_BUSY;
                    end else if (i_write_valid) begin
                        r_addr  <= i_write_address;
                        r_wdata <= i_write_data;
                        r_cnt   <= CNT_LOAD;
                        r_state <= RSP_WRITE_BUSY;
                    end
                end
                RSP_READ_BUSY: begin
                    if (w_cnt_zero) begin
                        r_rdata      <= i_mem_rdata;
                        r_read_ready <= 1'b1;
                        r_state      <= RSP_READ_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RSP_WRITE_BUSY: begin
                    if (w_cnt_zero) begin
                        r_write_ready <= 1'b1;
                        r_state       <= RSP_WRITE_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RSP_READ_DONE: begin
                    if (!i_read_valid) begin
                        r_read_ready <= 1'b0;
                        r_state      <= RSP_IDLE;
                    end
                end
                RSP_WRITE_DONE: begin
                    if (!i_write_valid) begin
                        r_write_ready <= 1'b0;
                        r_state       <= RSP_IDLE;
                    end
                end
                default: r_state <= RSP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel word memory with fixed response latency. Channels run
// independently; simultaneous writes to one word resolve to the lowest channel.
module mem_responder
    import states_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int WRITE_ENABLE = 1,
    parameter int LATENCY      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [NUM_CHANNELS-1:0]                 read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [NUM_CHANNELS-1:0]                 write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [NUM_CHANNELS-1:0]                 write_ready
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0]                   r_mem [DEPTH];
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] w_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_wdata;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_rdata;
    logic [NUM_CHANNELS-1:0]                w_wr_commit;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign w_rdata[c] = r_mem[w_addr[c]];

        mem_responder_chan #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY)
        ) u_chan (
            .clk             (clk),
            .reset           (reset),
            .i_read_valid    (read_valid[c]),
            .i_read_address  (read_address[c]),
            .i_write_valid   (write_valid[c]),
            .i_write_address (write_address[c]),
            .i_write_data    (write_data[c]),
            .i_mem_rdata     (w_rdata[c]),
            .o_read_ready    (read_ready[c]),
            .o_read_data     (read_data[c]),
            .o_write_ready   (write_ready[c]),
            .o_addr          (w_addr[c]),
            .o_wdata         (w_wdata[c]),
            .o_wr_commit     (w_wr_commit[c])
        );
    end

    // Highest channel is written first so the lowest index's update lands last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (WRITE_ENABLE != 0) begin
            for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
                if (w_wr_commit[c]) r_mem[w_addr[c]] <= w_wdata[c];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a 2-channel writable instance (LATENCY=2) and a 1-channel
// read-only instance (LATENCY=1) sharing clock and reset.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       rv, wv, rr, wr;
    logic [1:0][7:0]  ra, wa;
    logic [1:0][15:0] wd, rd;

    logic [0:0]       rv1, wv1, rr1, wr1;
    logic [0:0][7:0]  ra1, wa1;
    logic [0:0][15:0] wd1, rd1;

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .WRITE_ENABLE(1), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .read_valid(rv), .read_address(ra), .read_ready(rr), .read_data(rd),
        .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr)
    );

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .WRITE_ENABLE(0), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .read_valid(rv1), .read_address(ra1), .read_ready(rr1), .read_data(rd1),
        .write_valid(wv1), .write_address(wa1), .write_data(wd1), .write_ready(wr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        rv1 = '0; ra1 = '0; wv1 = '0; wa1 = '0; wd1 = '0;
        tick(); tick(); tick();
        chk("rst_rr0", 32'(rr), 32'h0);
        chk("rst_wr0", 32'(wr), 32'h0);
        chk("rst_rd0", 32'(rd), 32'h0);
        chk("rst_rr1", 32'(rr1), 32'h0);
        chk("rst_wr1", 32'(wr1), 32'h0);
        reset = 1'b1;
        tick();

        // Write 0x10 = 0xBEEF; inputs scrambled after sampling.
        wv[0] = 1'b1; wa[0] = 8'h10; wd[0] = 16'hBEEF;
        tick();
        wa[0] = 8'hFF; wd[0] = 16'h0000;
        chk("wr_lat_e1", 32'(wr[0]), 32'h0);
        tick();
        chk("wr_lat_e2", 32'(wr[0]), 32'h0);
        tick();
        chk("wr_ack_e3", 32'(wr[0]), 32'h1);
        wv[0] = 1'b0;
        tick();
        chk("wr_drop", 32'(wr[0]), 32'h0);

        // Read 0x10, then hold valid three more cycles.
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick();
        ra[0] = 8'h00;
        chk("rd_lat_e1", 32'(rr[0]), 32'h0);
        tick();
        chk("rd_lat_e2", 32'(rr[0]), 32'h0);
        tick();
        chk("rd_rdy_e3", 32'(rr[0]), 32'h1);
        chk("rd_data", 32'(rd[0]), 32'hBEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rd_hold_rdy", 32'(rr[0]), 32'h1);
            chk("rd_hold_data", 32'(rd[0]), 32'hBEEF);
        end
        rv[0] = 1'b0;
        tick();
        chk("rd_drop", 32'(rr[0]), 32'h0);

        // Back in IDLE: a fresh read takes the full latency again.
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick(); tick();
        chk("rd2_lat", 32'(rr[0]), 32'h0);
        tick();
        chk("rd2_rdy", 32'(rr[0]), 32'h1);
        chk("rd2_data", 32'(rd[0]), 32'hBEEF);
        rv[0] = 1'b0;
        tick();

        // Both channels write 0x05 on the same edge; ch0 wins.
        wv = 2'b11; wa[0] = 8'h05; wa[1] = 8'h05; wd[0] = 16'h1111; wd[1] = 16'h2222;
        tick(); tick(); tick();
        chk("dual_wr_ack", 32'(wr), 32'h3);
        wv = '0;
        tick();
        rv[1] = 1'b1; ra[1] = 8'h05;
        tick(); tick(); tick();
        chk("dual_rd_rdy", 32'(rr[1]), 32'h1);
        chk("dual_rd_data", 32'(rd[1]), 32'h1111);
        rv[1] = 1'b0;
        tick();

        // Read and write together on ch0: read first (old value), write after.
        rv[0] = 1'b1; ra[0] = 8'h30; wv[0] = 1'b1; wa[0] = 8'h30; wd[0] = 16'hCAFE;
        tick(); tick(); tick();
        chk("rw_rd_rdy", 32'(rr[0]), 32'h1);
        chk("rw_rd_old", 32'(rd[0]), 32'h0);
        chk("rw_wr_wait", 32'(wr[0]), 32'h0);
        rv[0] = 1'b0;
        tick();
        chk("rw_rd_drop", 32'(rr[0]), 32'h0);
        tick();
        chk("rw_wr_e1", 32'(wr[0]), 32'h0);
        tick();
        chk("rw_wr_e2", 32'(wr[0]), 32'h0);
        tick();
        chk("rw_wr_ack", 32'(wr[0]), 32'h1);
        wv[0] = 1'b0;
        tick();
        rv[0] = 1'b1; ra[0] = 8'h30;
        tick(); tick(); tick();
        chk("rw_rd_new", 32'(rd[0]), 32'hCAFE);
        rv[0] = 1'b0;
        tick();

        // Same-edge read (ch1) and write (ch0) to 0x40: read sees old value.
        wv[0] = 1'b1; wa[0] = 8'h40; wd[0] = 16'h7777;
        rv[1] = 1'b1; ra[1] = 8'h40;
        tick(); tick(); tick();
        chk("coll_wr_ack", 32'(wr[0]), 32'h1);
        chk("coll_rd_rdy", 32'(rr[1]), 32'h1);
        chk("coll_rd_old", 32'(rd[1]), 32'h0);
        wv[0] = 1'b0; rv[1] = 1'b0;
        tick();
        rv[1] = 1'b1;
        tick(); tick(); tick();
        chk("coll_rd_new", 32'(rd[1]), 32'h7777);
        rv[1] = 1'b0;
        tick();

        // Read-only instance, LATENCY=1: ack after one edge, memory untouched.
        wv1 = 1'b1; wa1[0] = 8'h20; wd1[0] = 16'h1234;
        tick();
        chk("ro_wr_e1", 32'(wr1), 32'h0);
        tick();
        chk("ro_wr_ack", 32'(wr1), 32'h1);
        wv1 = 1'b0;
        tick();
        rv1 = 1'b1; ra1[0] = 8'h20;
        tick();
        chk("ro_rd_e1", 32'(rr1), 32'h0);
        tick();
        chk("ro_rd_rdy", 32'(rr1), 32'h1);
        chk("ro_rd_data", 32'(rd1), 32'h0);
        rv1 = 1'b0;
        tick();

        // Write 0x3C, start a read, reset during READ_BUSY.
        wv[0] = 1'b1; wa[0] = 8'h3C; wd[0] = 16'hA5A5;
        tick(); tick(); tick();
        chk("rst_pre_wr", 32'(wr[0]), 32'h1);
        wv[0] = 1'b0;
        tick();
        rv[0] = 1'b1; ra[0] = 8'h3C;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_rr", 32'(rr[0]), 32'h0);
        rv[0] = 1'b0; reset = 1'b1;
        tick();
        chk("rst_post_rr", 32'(rr[0]), 32'h0);
        rv[0] = 1'b1;
        tick(); tick(); tick();
        chk("rst_rd_rdy", 32'(rr[0]), 32'h1);
        chk("rst_rd_data", 32'(rd[0]), 32'h0);
        rv[0] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, word address width; memory depth SHALL be 2**ADDR_BITS words.
REQ-002 Parameter DATA_BITS, default 16, word width.
REQ-003 Parameter NUM_CHANNELS, default 1, number of independent request channels.
REQ-004 Parameter WRITE_ENABLE, default 1; 0 = read-only (program memory).
REQ-005 Parameter LATENCY, default 2, cycles from request sample to ready (legal range >= 1).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (reset==0 resets on clk rising edge).
REQ-008 read_valid  input  [NUM_CHANNELS]  per-channel read request.
REQ-009 read_address  input  [NUM_CHANNELS][ADDR_BITS]  read word address.
REQ-010 read_ready  output  [NUM_CHANNELS]  read response valid.
REQ-011 read_data  output  [NUM_CHANNELS][DATA_BITS]  read response data.
REQ-012 write_valid  input  [NUM_CHANNELS]  per-channel write request.
REQ-013 write_address  input  [NUM_CHANNELS][ADDR_BITS]  write word address.
REQ-014 write_data  input  [NUM_CHANNELS][DATA_BITS]  write data.
REQ-015 write_ready  output  [NUM_CHANNELS]  write acknowledge.

Function
REQ-016 Each channel SHALL run an independent FSM: IDLE, READ_BUSY, WRITE_BUSY, READ_DONE, WRITE_DONE.
REQ-017 IDLE: read_valid high at edge T -> latch read_address, load counter = LATENCY-1, go READ_BUSY; else write_valid high -> latch address and data, go WRITE_BUSY.
REQ-018 Read and write both high in IDLE -> read SHALL win; write stays pending and is served after the read completes.
REQ-019 BUSY states SHALL decrement the counter each cycle; at zero -> go DONE, asserting ready, so ready is first high after edge T+LATENCY.
REQ-020 At the read-ready edge, read_data SHALL register mem[latched address], reflecting all writes committed at earlier edges.
REQ-021 At the write-ready edge the latched data SHALL be committed to mem[latched address] when WRITE_ENABLE=1; when WRITE_ENABLE=0 the memory is unchanged but write_ready is still asserted.
REQ-022 Changes to address/data inputs after sampling SHALL NOT affect the transaction.
REQ-023 DONE: ready and read_data held stable while the corresponding valid is high; valid low at an edge -> ready low, go IDLE (one-cycle minimum gap before the next sample).
REQ-024 Two channels committing writes to the same address at the same edge -> lowest channel index SHALL win; all channels still receive write_ready.
REQ-025 Read and write to the same address completing at the same edge -> read returns the old value.
REQ-026 Valid dropping during BUSY SHALL NOT abort; response still issued, then DONE exits at the next edge with valid low.

Reset
REQ-027 On reset==0: all FSMs -> IDLE, counters 0, read_ready/write_ready 0, read_data 0, all memory words 0.
REQ-028 Reset mid-transaction SHALL discard it; no partial write is committed.

Structure
REQ-029 responder_state_t (five states above) SHALL live in states_pkg beside controller_state_t.
REQ-030 Per-channel FSM + latency counter SHALL be sub-module mem_responder_chan, generated NUM_CHANNELS times; the storage array and write-priority resolution stay in the top.

Verification
REQ-031 LATENCY=2: write addr 0x10 data 0xBEEF, then read 0x10 -> write_ready high 2 cycles after sample; read_ready high 2 cycles after sample with read_data=0xBEEF.
REQ-032 read_valid held 3 cycles after ready -> ready and data stable 3 cycles; valid low -> ready low next edge, state IDLE.
REQ-033 NUM_CHANNELS=2, both write 0x05 (ch0 0x1111, ch1 0x2222) same cycle -> both acked; subsequent read 0x05 = 0x1111.
REQ-034 WRITE_ENABLE=0: write 0x20 data 0x1234 -> write_ready asserted; read 0x20 returns 0x0000.
REQ-035 read+write valid together on one channel -> read served first, then write; after completion read returns new value.
REQ-036 reset pulsed low during READ_BUSY after prior write 0x3C=0xA5A5 -> ready never asserted; read of 0x3C after reset returns 0x0000.
